// File: rtl/ofdm_pilot_framer.sv
`default_nettype none
// ============================================================================
// Module      : ofdm_pilot_framer
// Description : Adds comb BPSK pilots to data-only subcarrier beats and marks
//               symbol/frame edges. An optional BPSK sync symbol starts each
//               frame when OFDM_FRAMER_SYNC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ofdm_pilot_framer #(
    parameter int SYMBOLS_PER_FRAME = 10,
    parameter int USED_CARRIERS     = 800,
    parameter int CARRIERS_PER_BEAT = 10,
    parameter int PILOT_DENSITY     = 5,
    parameter int SC_WIDTH          = 4,
    parameter logic [SC_WIDTH-1:0] POS_CODE = 4'b0001,
    parameter logic [SC_WIDTH-1:0] NEG_CODE = 4'b0011,
    localparam int c_pilots_per_beat = CARRIERS_PER_BEAT / PILOT_DENSITY,
    localparam int c_data_slots      = CARRIERS_PER_BEAT - c_pilots_per_beat,
    localparam int c_bps             = USED_CARRIERS / CARRIERS_PER_BEAT
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic [c_data_slots*SC_WIDTH-1:0]      s_axis_data_tdata,
    input  logic                                  s_axis_data_tvalid,
    input  logic                                  s_axis_data_tlast,
    output logic                                  s_axis_data_tready,
    input  logic [USED_CARRIERS-1:0]              sync_word,
    output logic [CARRIERS_PER_BEAT*SC_WIDTH-1:0] m_axis_data_tdata,
    output logic                                  m_axis_data_tvalid,
    output logic                                  m_axis_data_tlast,
    output logic                                  m_axis_data_tuser,
    input  logic                                  m_axis_data_tready,
    output logic                                  err_tlast
);

    localparam int c_bcw = (c_bps > 1) ? $clog2(c_bps) : 1;
    localparam int c_scw = (SYMBOLS_PER_FRAME > 1) ? $clog2(SYMBOLS_PER_FRAME) : 1;
    localparam logic [c_bcw-1:0] c_beat_last = c_bcw'(c_bps - 1);
    localparam logic [c_scw-1:0] c_sym_last  = c_scw'(SYMBOLS_PER_FRAME - 1);
    localparam int c_ow = CARRIERS_PER_BEAT * SC_WIDTH;

    logic [c_bcw-1:0] r_beat_cnt;
    logic [c_scw-1:0] r_sym_cnt;
    logic             r_tvalid;
    logic [c_ow-1:0]  r_tdata;
    logic             r_tlast;
    logic             r_tuser;
    logic             r_err;

    logic             w_is_sync;
    logic             w_frame_first;
    logic             w_out_free;
    logic             w_load;
    logic             w_beat_last;
    logic             w_sym_last;
    logic             w_pilot_odd_base;
    logic [c_ow-1:0]  w_data_slots;
    logic [c_ow-1:0]  w_sync_slots;

`ifdef OFDM_FRAMER_SYNC_EN
    typedef enum logic [0:0] {
        ST_SYNC = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t                   r_state;
    logic [USED_CARRIERS-1:0] r_sync_reg;
    logic [CARRIERS_PER_BEAT-1:0] w_sync_bits;

    assign w_is_sync     = (r_state == ST_SYNC);
    assign w_frame_first = w_is_sync && (r_beat_cnt == '0);
    assign w_sync_bits   = r_sync_reg[int'(r_beat_cnt) * CARRIERS_PER_BEAT +: CARRIERS_PER_BEAT];

    for (genvar j = 0; j < CARRIERS_PER_BEAT; j++) begin : g_sync_slot
        assign w_sync_slots[j*SC_WIDTH +: SC_WIDTH] = w_sync_bits[j] ? POS_CODE : NEG_CODE;
    end
`else
    logic w_unused_sync;

    assign w_unused_sync = ^sync_word;
    assign w_is_sync     = 1'b0;
    assign w_frame_first = (r_beat_cnt == '0) && (r_sym_cnt == '0);
    assign w_sync_slots  = '0;
`endif

    assign w_beat_last = (r_beat_cnt == c_beat_last);
    assign w_sym_last  = (r_sym_cnt == c_sym_last);
    assign w_out_free  = !r_tvalid || m_axis_data_tready;
    assign w_load      = w_out_free && (w_is_sync || s_axis_data_tvalid);

    assign s_axis_data_tready = !areset && !w_is_sync && w_out_free;

    // Each beat holds P pilots, so the first pilot's index parity flips per beat only when P is odd
    assign w_pilot_odd_base = ((c_pilots_per_beat % 2) == 1) ? r_beat_cnt[0] : 1'b0;

    for (genvar j = 0; j < CARRIERS_PER_BEAT; j++) begin : g_slot
        if ((j % PILOT_DENSITY) == 0) begin : g_pilot
            localparam logic c_odd = (((j / PILOT_DENSITY) % 2) == 1);
            assign w_data_slots[j*SC_WIDTH +: SC_WIDTH] =
                (w_pilot_odd_base ^ c_odd) ? NEG_CODE : POS_CODE;
        end else begin : g_data
            assign w_data_slots[j*SC_WIDTH +: SC_WIDTH] =
                s_axis_data_tdata[(j - j / PILOT_DENSITY - 1)*SC_WIDTH +: SC_WIDTH];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_beat_cnt <= '0;
            r_sym_cnt  <= '0;
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_tlast    <= 1'b0;
            r_tuser    <= 1'b0;
            r_err      <= 1'b0;
`ifdef OFDM_FRAMER_SYNC_EN
            r_state    <= ST_SYNC;
            r_sync_reg <= sync_word;
`endif
        end else begin
            if (w_load) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_is_sync ? w_sync_slots : w_data_slots;
                r_tlast  <= w_beat_last;
                r_tuser  <= w_frame_first;
                if (!w_is_sync && (s_axis_data_tlast != w_beat_last)) begin
                    r_err <= 1'b1;
                end
                if (w_beat_last) begin
                    r_beat_cnt <= '0;
`ifdef OFDM_FRAMER_SYNC_EN
                    if (w_is_sync) begin
                        r_state <= ST_DATA;
                    end
`endif
                    if (!w_is_sync) begin
                        if (w_sym_last) begin
                            r_sym_cnt <= '0;
`ifdef OFDM_FRAMER_SYNC_EN
                            r_state    <= ST_SYNC;
                            r_sync_reg <= sync_word;
`endif
                        end else begin
                            r_sym_cnt <= r_sym_cnt + c_scw'(1);
                        end
                    end
                end else begin
                    r_beat_cnt <= r_beat_cnt + c_bcw'(1);
                end
            end else if (m_axis_data_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_data_tdata  = r_tdata;
    assign m_axis_data_tvalid = r_tvalid;
    assign m_axis_data_tlast  = r_tlast;
    assign m_axis_data_tuser  = r_tuser;
    assign err_tlast          = r_err;

endmodule
`default_nettype wire

// File: doc/ofdm_pilot_framer.md
# ofdm_pilot_framer

Parametrised OFDM frequency-domain framer between the QAM bit-packing stage and the IFFT input buffer. Takes AXI-Stream beats holding only data subcarriers and emits full subcarrier beats. It inserts comb pilots at a configurable density and alternating BPSK polarity, prepends an optional BPSK sync symbol to every frame, and marks symbol and frame boundaries. It also flags input framing errors.

## Interface
- SYMBOLS_PER_FRAME, 10: data symbols per frame, ≥1.
- USED_CARRIERS, 800: subcarriers per symbol; must be a multiple of CARRIERS_PER_BEAT.
- CARRIERS_PER_BEAT, 10: subcarrier slots per output beat (CPB); must be a multiple of PILOT_DENSITY.
- PILOT_DENSITY, 5: one pilot every PD subcarriers, at indices k with k % PD == 0.
- SC_WIDTH, 4: bits per subcarrier slot (SCW).
- POS_CODE, 4'b0001: SCW-bit code for BPSK +1.
- NEG_CODE, 4'b0011: SCW-bit code for BPSK −1.
- Derived: P = CPB/PD pilots per beat; D = CPB−P data slots per beat; BPS = USED_CARRIERS/CPB beats per symbol.
- aclk  in  1  the single clock.
- areset  in  1  synchronous, active-high reset.
- s_axis_data_tdata  in  D·SCW  data subcarriers; lowest slot in the LSBs.
- s_axis_data_tvalid  in  1  input valid.
- s_axis_data_tlast  in  1  asserted by the source on the last beat of each data symbol.
- s_axis_data_tready  out  1  input ready.
- sync_word  in  USED_CARRIERS  sync BPSK bits; bit k is subcarrier k.
- m_axis_data_tdata  out  CPB·SCW  subcarrier slots; slot 0 in the LSBs.
- m_axis_data_tvalid  out  1  output valid.
- m_axis_data_tlast  out  1  last beat of every symbol, sync or data.
- m_axis_data_tuser  out  1  first beat of every frame.
- m_axis_data_tready  in  1  downstream ready.
- err_tlast  out  1  sticky input tlast mismatch flag; cleared only by areset.

## Operation
- State machine: SYNC and DATA.
  - Reset state is SYNC, or DATA when the sync feature is compiled out.
- Counters:
  - beat_cnt counts 0..BPS−1.
  - sym_cnt counts 0..SYMBOLS_PER_FRAME−1 and counts data symbols only.
- SYNC:
  - sync_word is captured into an internal register on the cycle the state is entered, including the exit from reset.
  - Each beat b has slot j = sync_reg[b·CPB+j] ? POS_CODE : NEG_CODE.
  - s_axis_data_tready = 0 throughout.
  - After beat BPS−1 is transferred, the state moves to DATA and beat_cnt = 0.
- DATA:
  - Slots are filled in ascending j.
  - Slot j with j % PD == 0 is a pilot. Its global pilot index is p = (beat_cnt·CPB+j)/PD, and its value is POS_CODE if p is even, NEG_CODE if p is odd.
  - The remaining slots take successive SCW fields of s_axis_data_tdata, lowest field first.
- Symbol and frame sequencing:
  - On the last beat of a data symbol, sym_cnt increments.
  - When sym_cnt wraps at SYMBOLS_PER_FRAME−1, sym_cnt goes to 0 and the state goes to SYNC (or stays in DATA without the sync feature).
- m_axis_data_tlast is set when beat_cnt == BPS−1.
- m_axis_data_tuser is set on beat 0 of the frame's first symbol: the sync symbol if present, otherwise data symbol 0.
- err_tlast is set when an accepted input beat's tlast ≠ (beat_cnt == BPS−1). Counters are never resynchronised by tlast.

## Timing
- Single output register stage. An accepted input beat appears on m_axis_data_* on the next cycle.
- s_axis_data_tready = (state == DATA) && (!m_axis_data_tvalid || m_axis_data_tready). It is combinational from the register state and m_axis_data_tready.
- SYNC beats load the output register under the same condition, without any input.
- Throughput is 1 beat per cycle while m_axis_data_tready is held high.
- Frame length is BPS·(SYMBOLS_PER_FRAME+1) output beats; the +1 is dropped without sync.
- Output stability: while m_axis_data_tvalid && !m_axis_data_tready, tdata, tlast and tuser hold stable.
- Reset values: m_axis_data_tvalid, tdata, tlast, tuser, err_tlast = 0; s_axis_data_tready = 0 while areset is high; counters = 0.
- Reset mid-frame discards any beat held in the output register. The first beat after reset is beat 0 of a new frame with tuser = 1.
- A symbol-end and a frame-end on the same transfer are both applied in that cycle; there is no bubble between symbols or frames.
- sync_word changes outside the capture cycle do not affect the sync symbol in progress.

## Configuration
- OFDM_FRAMER_SYNC_EN defined:
  - The SYNC state, sync register and sync symbol are built.
  - A frame is one sync symbol followed by SYMBOLS_PER_FRAME data symbols.
- OFDM_FRAMER_SYNC_EN undefined:
  - No SYNC state and no sync register; sync_word remains as a port but is ignored.
  - A frame is SYMBOLS_PER_FRAME data symbols, and tuser marks beat 0 of data symbol 0.

## Test plan
- Defaults with SYNC_EN, sync_word = all ones, m_tready = 1 -> first 80 beats have every slot = 4'b0001, s_tready = 0, tuser = 1 only on beat 0, tlast on beat 79.
- Data beat s_tdata = 32'h87654321 -> output slots (0..9) = 1,1,2,3,4,3,5,6,7,8: pilots at slots 0 and 5 are POS then NEG, and the data nibbles appear in order.
- Stream 10 data symbols of 80 beats each with correct tlast -> 880 beats per frame; the next beat is a sync beat with tuser = 1; err_tlast stays 0.
- Random m_tready throttling at 50% -> no beat lost or duplicated, and held tdata does not change while stalled.
- Input tlast on beat 40 of a data symbol -> err_tlast = 1 one cycle later and stays set; output tlast is still asserted on beat 79.
- Assert areset during beat 300 of a frame -> all outputs are 0 during reset; the first post-reset beat is a sync beat with tuser = 1. Without SYNC_EN, the first post-reset beat is data beat 0 with tuser = 1.
